ram16k_arbiter: RTL and testbench

//   Shares one RAM16K (single-port SPRAM, 1-cycle read latency) between two requesters:

---
 rtl/ram_arb_pkg.sv | 41 ++++
 rtl/ram_arb_quota.sv | 39 +++
 rtl/ram16k_arbiter.sv | 84 ++++++++
 tb/tb_ram16k_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and the grant-selection rule for the RAM16K two-port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam int BURST_MAX_DEFAULT = 8;

  typedef struct packed {
    logic a;
    logic b;
  } grant_t;

  // The owner keeps the RAM while under quota; once the quota is used up a
  // waiting non-owner takes over. A lone requester always wins.
  function automatic grant_t pick_winner(
    input owner_t      owner,
    input int unsigned streak,
    input int unsigned burst_max,
    input logic        a_req,
    input logic        b_req
  );
    grant_t g;
    g = '0;
    if (a_req && b_req) begin
      if (streak < burst_max) begin
        g.a = (owner == OWN_A);
      end else begin
        g.a = (owner == OWN_B);
      end
      g.b = ~g.a;
    end else begin
      g.a = a_req;
      g.b = b_req;
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_arb_quota.sv
// Tracks which side currently owns the RAM and how many consecutive grants it has had.
module ram_arb_quota
  import ram_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT,
  parameter int SW        = $clog2(BURST_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gnt_a,
  input  logic          gnt_b,
  output owner_t        owner,
  output logic [SW-1:0] streak
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(BURST_MAX);

  owner_t gnt_side;

  assign gnt_side = gnt_b ? OWN_B : OWN_A;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= OWN_A;
      streak <= '0;
    end else if (gnt_a || gnt_b) begin
      if (gnt_side == owner) begin
        if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else begin
        owner  <= gnt_side;
        streak <= SW'(1);
      end
    end else begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares one single-port RAM16K between port A (CPU) and port B (screen/DMA) with a burst quota.
module ram16k_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int SW = $clog2(BURST_MAX + 1);

  owner_t        owner;
  logic [SW-1:0] streak;
  grant_t        win;

  assign win   = pick_winner(owner, 32'(streak), BURST_MAX, a_req, b_req);
  // Reset wins over any request so nothing reaches the RAM in a reset cycle.
  assign a_gnt = win.a & ~reset;
  assign b_gnt = win.b & ~reset;

  ram_arb_quota #(
    .BURST_MAX (BURST_MAX),
    .SW        (SW)
  ) u_quota (
    .clk    (clk),
    .reset  (reset),
    .gnt_a  (a_gnt),
    .gnt_b  (b_gnt),
    .owner  (owner),
    .streak (streak)
  );

  // NOTE: every output is defaulted first so this mux can never infer a latch.
  always_comb begin
    ram_load = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    if (a_gnt) begin
      ram_load = a_we;
      ram_addr = a_addr;
      ram_in   = a_wdata;
    end else if (b_gnt) begin
      ram_load = b_we;
      ram_addr = b_addr;
      ram_in   = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  // The RAM has a single read port, so both sides see its output; rvalid says whose it is.
  assign a_rdata = ram_out;
  assign b_rdata = ram_out;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter: drives per-cycle vectors, scoreboards read returns.
module tb_ram16k_arbiter;

  localparam int NONE = 0;
  localparam int GA   = 1;
  localparam int GB   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [13:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load;
  logic [15:0] a_rdata, b_rdata, ram_in;
  logic [15:0] ram_out = '0;
  logic [13:0] ram_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    bit          side_b;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem    [0:16383];
  logic [15:0] shadow [0:16383];

  ram16k_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural RAM16K: registered read, write visible to the next read.
  initial for (int i = 0; i < 16384; i++) begin
    mem[i]    = '0;
    shadow[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
    ram_out <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; exp_side is the hand-derived winner for this cycle.
  task automatic drive(input bit rst,
                       input logic ar, input logic aw, input logic [13:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [13:0] ba, input logic [15:0] bd,
                       input int exp_side);
    exp_t e;
    @(negedge clk);
    reset = rst;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #2;
    check("a_gnt", 32'(a_gnt), 32'(exp_side == GA));
    check("b_gnt", 32'(b_gnt), 32'(exp_side == GB));
    if (exp_side == GA) begin
      check("ram_load", 32'(ram_load), 32'(aw));
      check("ram_addr", 32'(ram_addr), 32'(aa));
      if (aw) check("ram_in", 32'(ram_in), 32'(ad));
    end else if (exp_side == GB) begin
      check("ram_load", 32'(ram_load), 32'(bw));
      check("ram_addr", 32'(ram_addr), 32'(ba));
      if (bw) check("ram_in", 32'(ram_in), 32'(bd));
    end else begin
      check("idle_ram_load", 32'(ram_load), 32'd0);
      check("idle_ram_addr", 32'(ram_addr), 32'd0);
    end
    if (exp_side == GA) begin
      if (aw) shadow[aa] = ad;
      else begin
        e.due = cyc + 1; e.side_b = 1'b0; e.data = shadow[aa];
        sb.push_back(e);
      end
    end else if (exp_side == GB) begin
      if (bw) shadow[ba] = bd;
      else begin
        e.due = cyc + 1; e.side_b = 1'b1; e.data = shadow[ba];
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 14'h0, 16'h0, 0, 0, 14'h0, 16'h0, NONE);
  endtask

  // Monitor: whenever a read return is presented, pop and compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("rvalid_missing", 32'd0, 32'd1);
      end
      if (a_rvalid || b_rvalid) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          check("a_rvalid", 32'(a_rvalid), 32'(!e.side_b));
          check("b_rvalid", 32'(b_rvalid), 32'(e.side_b));
          check("rdata", 32'(e.side_b ? b_rdata : a_rdata), 32'(e.data));
        end else begin
          check("spurious_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bi;
    int exp_side;

    // Reset: nothing granted, nothing driven to the RAM.
    drive(1, 0, 0, 14'h0, 16'h0, 0, 0, 14'h0, 16'h0, NONE);
    drive(1, 1, 0, 14'h10, 16'h0, 0, 0, 14'h0, 16'h0, NONE);
    check("reset_a_rvalid", 32'(a_rvalid), 32'd0);

    // 1: A writes 0x1234 @0x0010 then reads it back.
    drive(0, 1, 1, 14'h0010, 16'h1234, 0, 0, 14'h0, 16'h0, GA);
    drive(0, 1, 0, 14'h0010, 16'h0000, 0, 0, 14'h0, 16'h0, GA);
    idle(2);

    // 2: both request continuously -> A x8, B x8, A x8.
    bi = 0;
    for (int i = 0; i < 24; i++) begin
      exp_side = (i < 8 || i >= 16) ? GA : GB;
      drive(0, 1, 0, 14'h0010, 16'h0, 1, 1, 14'(14'h0100 + bi), 16'(16'hB000 + bi), exp_side);
      if (exp_side == GB) bi++;
    end
    idle(1);

    // 3: B alone for 20 back-to-back reads.
    for (int i = 0; i < 20; i++)
      drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'(14'h0100 + (i % 8)), 16'h0, GB);
    idle(1);

    // 4: B builds streak 3, then A joins: B gets 5 more, then A; A holds with B idle.
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'(14'h0100 + i), 16'h0, GB);
    for (int i = 0; i < 6; i++)
      drive(0, 1, 0, 14'h0010, 16'h0, 1, 0, 14'h0105, 16'h0, (i < 5) ? GB : GA);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 14'h0010, 16'h0, 0, 0, 14'h0, 16'h0, GA);
    idle(1);

    // 5: make B owner, then reset in a cycle where A would be granted a read.
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'h0101, 16'h0, GB);
    drive(1, 1, 0, 14'h0010, 16'h0, 0, 0, 14'h0, 16'h0, NONE);
    check("post_reset_ram_load", 32'(ram_load), 32'd0);
    for (int i = 0; i < 9; i++)
      drive(0, 1, 0, 14'h0010, 16'h0, 1, 0, 14'h0102, 16'h0, (i < 8) ? GA : GB);
    idle(1);

    // 6: top address via B, interleaved with A at address 0.
    drive(0, 1, 1, 14'h0000, 16'hA5A5, 0, 0, 14'h0, 16'h0, GA);
    drive(0, 0, 0, 14'h0, 16'h0, 1, 1, 14'h3FFF, 16'hBEEF, GB);
    drive(0, 1, 0, 14'h0000, 16'h0, 0, 0, 14'h0, 16'h0, GA);
    drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'h3FFF, 16'h0, GB);
    drive(0, 1, 0, 14'h0000, 16'h0, 0, 0, 14'h0, 16'h0, GA);
    drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'h3FFF, 16'h0, GB);
    drive(0, 1, 0, 14'h0000, 16'h0, 1, 0, 14'h3FFF, 16'h0, GB);
    drive(0, 1, 0, 14'h0000, 16'h0, 0, 0, 14'h0, 16'h0, GA);
    drive(0, 0, 0, 14'h0, 16'h0, 1, 1, 14'h3FFF, 16'h1111, GB);
    drive(0, 0, 0, 14'h0, 16'h0, 1, 0, 14'h3FFF, 16'h0, GB);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
